axis_frame_gen: RTL and testbench
=================================

AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16, frame length field width in bytes.
REQ-002 SHALL have parameter IFG_WIDTH, default 8, inter-frame gap field width in cycles.
REQ-003 SHALL fix the AXIS data width at 32 bits (4 byte lanes); not a parameter.
REQ-004 SHALL have one clock and an asynchronous active-low reset: i_clk  in  1  sole clock; all logic rising-edge.
REQ-005 i_reset_n  in  1  asynchronous active-low reset.
REQ-006 i_enable  in  1  level; high starts and continues frame generation.
REQ-007 i_frame_len  in  LEN_WIDTH  frame length in bytes; sampled at frame start.
REQ-008 i_ifg_cycles  in  IFG_WIDTH  idle cycles between frames; sampled at frame end.
REQ-009 i_frame_count  in  16  frames per run; 0 = continuous.
REQ-010 m00_axis_tdata  out  32  frame payload, byte k in lane k mod 4 (little-endian).
REQ-011 m00_axis_tkeep  out  4  byte-lane valid.
REQ-012 m00_axis_tvalid  out  1  AXIS valid.
REQ-013 m00_axis_tready  in  1  AXIS ready from the MAC transmit slave.
REQ-014 m00_axis_tlast  out  1  final beat of frame.
REQ-015 o_busy  out  1  high in SEND or GAP.
REQ-016 o_done  out  1  high in DONE.
REQ-017 o_frames_sent  out  32  count of frames whose tlast beat completed; wraps at 2^32.

Function
REQ-018 SHALL implement states IDLE, SEND, GAP, DONE.
REQ-019 IDLE -> SEND on the cycle after i_enable is sampled high; latch i_frame_len, set byte index 0.
REQ-020 i_frame_len of 0 SHALL be treated as 1.
REQ-021 Payload byte k of frame n SHALL be (n[7:0] + k) mod 256, where n = o_frames_sent at frame start.
REQ-022 Beat transfers only when tvalid and tready are both high; each transfer advances byte index by 4.
REQ-023 While tvalid is high and tready is low, tdata/tkeep/tlast SHALL hold stable; tvalid SHALL NOT drop.
REQ-024 Non-final beats: tkeep = 4'b1111; final beat: tkeep has ((len-1) mod 4)+1 contiguous LSB ones, tlast = 1; unused lanes drive 0.
REQ-025 tvalid SHALL be high continuously in SEND; no bubbles are inserted by the generator.
REQ-026 On final-beat transfer: o_frames_sent increments; if i_frame_count != 0 and new count == i_frame_count -> DONE; else if i_ifg_cycles == 0 and i_enable -> SEND next cycle (back-to-back); else -> GAP.
REQ-027 GAP SHALL hold tvalid low for exactly i_ifg_cycles cycles, then -> SEND if i_enable, else IDLE.
REQ-028 i_enable deasserted mid-frame SHALL NOT truncate the frame; the frame completes, then -> IDLE, skipping GAP.
REQ-029 DONE holds tvalid low; DONE -> IDLE when i_enable is low; o_frames_sent holds its value.
REQ-030 IDLE -> SEND resets neither o_frames_sent nor the pattern seed; only reset clears them.
REQ-031 Latency: first beat tvalid is high 1 cycle after i_enable is first sampled high in IDLE.

Reset
REQ-032 Reset assertion SHALL force IDLE immediately; tvalid, tlast, o_busy, o_done = 0; tdata = 0, tkeep = 0; o_frames_sent = 0.
REQ-033 Reset mid-frame SHALL abandon the frame with no tlast; after release, the next frame starts at byte 0, seed 0.
REQ-034 Reset release SHALL be synchronised internally; the first state change occurs no earlier than the 2nd rising edge after deassertion.

Configuration
REQ-035 Macro AXIS_FRAME_GEN_SEQNUM_EN: when defined, the first beat of each frame carries the 32-bit value n (frame index) little-endian in place of pattern bytes 0-3; later bytes keep the REQ-021 pattern; for frames under 4 bytes, only the low len bytes of n are sent, under the REQ-024 tkeep.
REQ-036 When undefined, all bytes follow REQ-021 and no sequence logic is synthesised.

Verification
REQ-037 len=64, ifg=3, count=2, tready=1 -> 16 beats each, frame0 first beat 0x03020100, 3 idle cycles, frame1 first beat 0x04030201, o_done, o_frames_sent=2.
REQ-038 len=61, count=1 -> 16 beats, last tkeep=4'b0001, tlast only on beat 16.
REQ-039 len=8, tready toggled 1/0 each cycle -> data held stable while stalled, 2 transfers, no dropped or duplicated beats.
REQ-040 count=0, ifg=0, i_enable dropped mid frame 3 -> frame 3 completes with tlast, -> IDLE, o_frames_sent=4, no gap cycles between frames 0-3.
REQ-041 Reset asserted on beat 5 of len=64 frame -> outputs 0 that cycle; after re-enable, first beat 0x03020100.
REQ-042 With AXIS_FRAME_GEN_SEQNUM_EN, len=3, frame 2 -> single beat tdata[23:0]=0x000002, tkeep=4'b0111, tlast=1.

Source files
------------

// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI-Stream test frame generator with a 32-bit data path.
// Each frame carries an incrementing byte pattern seeded by the frame index.
// Frames are separated by a programmable idle gap, and a run can be bounded
// by a frame count.
// Optional feature macro: AXIS_FRAME_GEN_SEQNUM_EN. When it is defined, the
// first beat of each frame carries the 32-bit frame index.
module axis_frame_gen #(
  parameter int LEN_WIDTH = 16,
  parameter int IFG_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic [LEN_WIDTH-1:0] i_frame_len,
  input  logic [IFG_WIDTH-1:0] i_ifg_cycles,
  input  logic [15:0]          i_frame_count,
  output logic [31:0]          m00_axis_tdata,
  output logic [3:0]           m00_axis_tkeep,
  output logic                 m00_axis_tvalid,
  input  logic                 m00_axis_tready,
  output logic                 m00_axis_tlast,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [31:0]          o_frames_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           rst_sync;
  logic                 run_ok;
  logic [LEN_WIDTH-1:0] byte_idx;
  logic [LEN_WIDTH-1:0] byte_idx_next;
  logic [LEN_WIDTH-1:0] frame_len;
  logic [LEN_WIDTH-1:0] frame_len_next;
  logic [LEN_WIDTH-1:0] len_sampled;
  logic [LEN_WIDTH-1:0] remaining;
  logic [IFG_WIDTH-1:0] gap_cnt;
  logic [IFG_WIDTH-1:0] gap_cnt_next;
  logic [31:0]          frames_sent_next;
  logic [31:0]          count_after;
  logic                 last_beat;
  logic                 beat_fire;
  logic [3:0]           keep_int;
  logic [31:0]          data_int;

  // Two-flop release synchroniser: assertion is immediate, release waits two edges
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run_ok      = rst_sync[1];
  assign len_sampled = (i_frame_len == '0) ? LEN_WIDTH'(1) : i_frame_len;
  assign remaining   = frame_len - byte_idx;
  assign last_beat   = (remaining <= LEN_WIDTH'(4));
  assign beat_fire   = (state == SEND) && m00_axis_tready;
  assign count_after = o_frames_sent + 32'd1;

  // State and datapath registers; held at reset values until release is synchronised
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      byte_idx      <= '0;
      frame_len     <= LEN_WIDTH'(1);
      gap_cnt       <= '0;
      o_frames_sent <= '0;
    end else if (!run_ok) begin
      state         <= IDLE;
      byte_idx      <= '0;
      frame_len     <= LEN_WIDTH'(1);
      gap_cnt       <= '0;
      o_frames_sent <= '0;
    end else begin
      state         <= state_next;
      byte_idx      <= byte_idx_next;
      frame_len     <= frame_len_next;
      gap_cnt       <= gap_cnt_next;
      o_frames_sent <= frames_sent_next;
    end
  end

  // Next-state logic: frame start, beat advance, end-of-frame decision and gap countdown
  always_comb begin
    state_next       = state;
    byte_idx_next    = byte_idx;
    frame_len_next   = frame_len;
    gap_cnt_next     = gap_cnt;
    frames_sent_next = o_frames_sent;
    case (state)
      IDLE: begin
        if (i_enable) begin
          state_next     = SEND;
          byte_idx_next  = '0;
          frame_len_next = len_sampled;
        end
      end
      SEND: begin
        if (beat_fire) begin
          if (last_beat) begin
            frames_sent_next = count_after;
            byte_idx_next    = '0;
            if ((i_frame_count != 16'd0) && (count_after == {16'd0, i_frame_count})) begin
              state_next = DONE;
            end else if (!i_enable) begin
              state_next = IDLE;
            end else if (i_ifg_cycles == '0) begin
              state_next     = SEND;
              frame_len_next = len_sampled;
            end else begin
              state_next   = GAP;
              gap_cnt_next = i_ifg_cycles;
            end
          end else begin
            byte_idx_next = byte_idx + LEN_WIDTH'(4);
          end
        end
      end
      GAP: begin
        if (gap_cnt <= IFG_WIDTH'(1)) begin
          gap_cnt_next = '0;
          if (i_enable) begin
            state_next     = SEND;
            byte_idx_next  = '0;
            frame_len_next = len_sampled;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt - IFG_WIDTH'(1);
        end
      end
      DONE: begin
        if (!i_enable) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stream outputs derived from registered state, so they stay stable during a stall
  always_comb begin
    keep_int        = 4'b0000;
    data_int        = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    if (state == SEND) begin
      m00_axis_tvalid = 1'b1;
      m00_axis_tlast  = last_beat;
      if (last_beat) begin
        case (remaining[1:0])
          2'd1:    keep_int = 4'b0001;
          2'd2:    keep_int = 4'b0011;
          2'd3:    keep_int = 4'b0111;
          default: keep_int = 4'b1111;
        endcase
      end else begin
        keep_int = 4'b1111;
      end
      for (int lane = 0; lane < 4; lane++) begin
        if (keep_int[lane]) begin
          data_int[lane*8 +: 8] = o_frames_sent[7:0] + byte_idx[7:0] + 8'(lane);
        end
      end
`ifdef AXIS_FRAME_GEN_SEQNUM_EN
      if (byte_idx == '0) begin
        data_int = o_frames_sent & {{8{keep_int[3]}}, {8{keep_int[2]}},
                                    {8{keep_int[1]}}, {8{keep_int[0]}}};
      end
`endif
    end
    m00_axis_tkeep = keep_int;
    m00_axis_tdata = data_int;
  end

  assign o_busy = (state == SEND) || (state == GAP);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb_axis_frame_gen: self-checking bench for axis_frame_gen.
// Expected beats come from a byte-level frame model (byte k of frame n is
// (n + k) mod 256). The first four bytes become the frame index when
// AXIS_FRAME_GEN_SEQNUM_EN is defined.
module tb_axis_frame_gen;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_enable;
  logic [15:0] i_frame_len;
  logic [7:0]  i_ifg_cycles;
  logic [15:0] i_frame_count;
  logic [31:0] m00_axis_tdata;
  logic [3:0]  m00_axis_tkeep;
  logic        m00_axis_tvalid;
  logic        m00_axis_tready;
  logic        m00_axis_tlast;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_frames_sent;

  int checks;
  int failures;
  int model_sent;
  int model_k;

  axis_frame_gen #(
    .LEN_WIDTH(16),
    .IFG_WIDTH(8)
  ) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_enable        (i_enable),
    .i_frame_len     (i_frame_len),
    .i_ifg_cycles    (i_ifg_cycles),
    .i_frame_count   (i_frame_count),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tkeep  (m00_axis_tkeep),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m00_axis_tready),
    .m00_axis_tlast  (m00_axis_tlast),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_frames_sent   (o_frames_sent)
  );

  // Free-running 100 MHz clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int len, input int ifg, input int cnt, input logic en);
    i_frame_len   = 16'(len);
    i_ifg_cycles  = 8'(ifg);
    i_frame_count = 16'(cnt);
    i_enable      = en;
  endtask

  // Expected beat starting at byte k0 of frame n with effective length eff_len
  function automatic void modelBeat(input int n, input int k0, input int eff_len,
                                    output logic [31:0] d, output logic [3:0] keep,
                                    output logic last);
    int k;
    d    = '0;
    keep = '0;
    for (int j = 0; j < 4; j++) begin
      k = k0 + j;
      if (k < eff_len) begin
        keep[j]      = 1'b1;
        d[j*8 +: 8]  = 8'((n + k) % 256);
`ifdef AXIS_FRAME_GEN_SEQNUM_EN
        if (k < 4) d[j*8 +: 8] = 8'((n >> (8 * k)) & 255);
`endif
      end
    end
    last = (k0 + 4 >= eff_len);
  endfunction

  // Runs frames from IDLE and checks every beat, the gaps and the end-of-run state.
  // ready_mode: -1 toggles tready each cycle, otherwise percent chance tready is high.
  task automatic runFrames(input string name, input int len, input int ifg, input int cnt,
                           input int ready_mode, input int drop_at, input int exp_frames);
    int          eff_len;
    int          frames_done;
    int          idle_run;
    int          cycles;
    bit          first_obs;
    bit          dropped;
    bit          gap_pending;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
    eff_len     = (len == 0) ? 1 : len;
    frames_done = 0;
    idle_run    = 0;
    cycles      = 0;
    first_obs   = 1'b1;
    dropped     = 1'b0;
    gap_pending = 1'b0;
    m00_axis_tready = 1'b0;
    applyStimulus(len, ifg, cnt, 1'b1);
    while (frames_done < exp_frames) begin
      @(negedge i_clk);
      cycles++;
      if (cycles > 3000) begin
        checkOutput({name, "_timeout"}, 32'(frames_done), 32'(exp_frames));
        break;
      end
      if (first_obs) begin
        checkOutput({name, "_latency"}, 32'(m00_axis_tvalid), 32'd1);
        first_obs = 1'b0;
      end
      if (model_k != 0) checkOutput({name, "_valid_held"}, 32'(m00_axis_tvalid), 32'd1);
      if (m00_axis_tvalid) begin
        if (gap_pending) begin
          checkOutput({name, "_gap"}, 32'(idle_run), 32'(ifg));
          gap_pending = 1'b0;
        end
        modelBeat(model_sent, model_k, eff_len, exp_data, exp_keep, exp_last);
        checkOutput({name, "_data"}, m00_axis_tdata, exp_data);
        checkOutput({name, "_keep"}, 32'(m00_axis_tkeep), 32'(exp_keep));
        checkOutput({name, "_last"}, 32'(m00_axis_tlast), 32'(exp_last));
        checkOutput({name, "_busy"}, 32'(o_busy), 32'd1);
      end else begin
        idle_run++;
      end
      if (ready_mode < 0) m00_axis_tready = ~m00_axis_tready;
      else m00_axis_tready = ($urandom_range(100, 1) <= ready_mode);
      if (m00_axis_tvalid && m00_axis_tready) begin
        model_k += 4;
        if (model_k >= eff_len) begin
          model_k = 0;
          model_sent++;
          frames_done++;
          idle_run    = 0;
          gap_pending = 1'b1;
        end
      end
      if (drop_at >= 0 && !dropped && frames_done == drop_at && model_k > 0) begin
        i_enable = 1'b0;
        dropped  = 1'b1;
      end
    end
    @(negedge i_clk);
    checkOutput({name, "_end_valid"}, 32'(m00_axis_tvalid), 32'd0);
    checkOutput({name, "_end_done"}, 32'(o_done), (cnt != 0) ? 32'd1 : 32'd0);
    checkOutput({name, "_end_busy"}, 32'(o_busy), 32'd0);
    checkOutput({name, "_frames_sent"}, o_frames_sent, 32'(model_sent));
    i_enable = 1'b0;
    repeat (2) @(negedge i_clk);
    checkOutput({name, "_idle_done"}, 32'(o_done), 32'd0);
    checkOutput({name, "_idle_busy"}, 32'(o_busy), 32'd0);
  endtask

  // Directed and randomized sequence
  initial begin
    int beats;
    int nfr;
    checks     = 0;
    failures   = 0;
    model_sent = 0;
    model_k    = 0;
    i_reset_n  = 1'b0;
    m00_axis_tready = 1'b0;
    applyStimulus(8, 0, 0, 1'b0);
    repeat (3) @(negedge i_clk);

    checkOutput("rst_tvalid", 32'(m00_axis_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(m00_axis_tlast), 32'd0);
    checkOutput("rst_tdata", m00_axis_tdata, 32'd0);
    checkOutput("rst_tkeep", 32'(m00_axis_tkeep), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_frames_sent", o_frames_sent, 32'd0);

    i_enable  = 1'b1;
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("sync_hold_valid", 32'(m00_axis_tvalid), 32'd0);
    checkOutput("sync_hold_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_enable = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("sync_idle_valid", 32'(m00_axis_tvalid), 32'd0);

    runFrames("len64_cnt2", 64, 3, 2, 100, -1, 2);
    runFrames("len61_cnt1", 61, 0, model_sent + 1, 100, -1, 1);
    runFrames("len8_toggle", 8, 0, model_sent + 1, -1, -1, 1);
    runFrames("len3_short", 3, 1, model_sent + 3, 100, -1, 3);

    for (int r = 0; r < 6; r++) begin
      nfr = int'($urandom_range(3, 1));
      runFrames("rand", int'($urandom_range(23, 0)), int'($urandom_range(4, 0)),
                model_sent + nfr, int'($urandom_range(100, 30)), -1, nfr);
    end

    runFrames("drop_mid", 20, 0, 0, 100, 3, 4);

    applyStimulus(64, 3, 0, 1'b1);
    m00_axis_tready = 1'b1;
    beats = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (m00_axis_tvalid) beats++;
      if (beats == 5) break;
    end
    checkOutput("midrst_reached", 32'(beats), 32'd5);
    i_reset_n = 1'b0;
    #1;
    checkOutput("midrst_tvalid", 32'(m00_axis_tvalid), 32'd0);
    checkOutput("midrst_tlast", 32'(m00_axis_tlast), 32'd0);
    checkOutput("midrst_tdata", m00_axis_tdata, 32'd0);
    checkOutput("midrst_tkeep", 32'(m00_axis_tkeep), 32'd0);
    checkOutput("midrst_busy", 32'(o_busy), 32'd0);
    checkOutput("midrst_frames_sent", o_frames_sent, 32'd0);
    model_sent = 0;
    model_k    = 0;
    i_enable   = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    runFrames("after_rst", 64, 2, 1, 100, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
